// File: rtl/puzzle_grid_engine.sv
// puzzle_grid_engine: N x N colour grid with row/column moves, LFSR scramble, move counter and solved flag
module puzzle_grid_engine #(
  parameter int N = 4,
  parameter int STATE_BITS = 2,
  parameter int SCRAMBLE_MOVES = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fire,
  input  logic [N-1:0]                sel_onehot,
  input  logic                        n_row,
  input  logic                        add_n,
  input  logic                        scramble_start,
  output logic                        sel_error,
  output logic                        busy,
  output logic [N*N*STATE_BITS-1:0]   state_vec,
  output logic                        win,
  output logic [15:0]                 move_count
);
  localparam int IW = $clog2(N);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
  localparam logic [9:0] SM = SCRAMBLE_MOVES[9:0];
  localparam logic [IW:0] NL = N[IW:0];
  typedef enum logic {IDLE, SCRAMBLE} state_t;
  state_t state, state_n;
  logic [STATE_BITS-1:0] cells [N*N];
  logic [STATE_BITS-1:0] delta;
  logic [15:0] lfsr;
  logic [9:0] scnt, scnt_n;
  logic [IW-1:0] idx;
  logic [N-1:0] mask;
  logic apply, col, dec, done, all_eq, win_q;
  assign sel_error = $countones(sel_onehot) != 1;
  assign busy = state == SCRAMBLE;
  assign win = win_q & ~busy;
  assign idx = lfsr[IW-1:0];
  assign delta = dec ? '1 : STATE_BITS'(1);
  always_comb begin
    state_n = state;
    scnt_n = scnt;
    apply = 1'b0;
    col = n_row;
    dec = add_n;
    mask = sel_onehot;
    done = 1'b0;
    if (state == IDLE) begin
      if (scramble_start) begin
        state_n = SCRAMBLE;
        scnt_n = '0;
      end else apply = fire && !sel_error;
    end else begin
      col = lfsr[15];
      dec = 1'b0;
      mask = {{(N-1){1'b0}}, 1'b1} << idx;
      if ({1'b0, idx} < NL) begin
        apply = 1'b1;
        scnt_n = scnt + 10'd1;
        done = scnt_n == SM;
        state_n = done ? IDLE : SCRAMBLE;
      end
    end
  end
  always_comb begin
    all_eq = 1'b1;
    for (int i = 0; i < N*N; i++) begin
      state_vec[i*STATE_BITS +: STATE_BITS] = cells[i];
      if (cells[i] != cells[0]) all_eq = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      scnt <= '0;
      lfsr <= SEED;
      move_count <= '0;
      win_q <= 1'b0;
      for (int i = 0; i < N*N; i++) cells[i] <= '0;
    end else begin
      state <= state_n;
      scnt <= scnt_n;
      lfsr <= lfsr[0] ? (lfsr >> 1) ^ 16'hB400 : lfsr >> 1;
      win_q <= all_eq;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          if (apply && (col ? mask[c] : mask[r])) cells[r*N+c] <= cells[r*N+c] + delta;
      if (done) move_count <= '0;
      else if (state == IDLE && apply && move_count != 16'hFFFF) move_count <= move_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_puzzle_grid_engine.sv
// tb_puzzle_grid_engine: directed checks of moves, wrap, select errors, scramble and reset abort
module tb_puzzle_grid_engine;
  logic clk = 0, reset = 1, fire = 0, n_row = 0, add_n = 0, scramble_start = 0;
  logic [3:0] sel_onehot = 4'b0001;
  logic sel_error, busy, win;
  logic [31:0] state_vec;
  logic [15:0] move_count;
  logic [15:0] m_lfsr;
  int asserts = 0, fails = 0;
  puzzle_grid_engine dut (
    .clk(clk), .reset(reset), .fire(fire), .sel_onehot(sel_onehot), .n_row(n_row),
    .add_n(add_n), .scramble_start(scramble_start), .sel_error(sel_error), .busy(busy),
    .state_vec(state_vec), .win(win), .move_count(move_count)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] nx(input logic [15:0] l);
    return l[0] ? (l >> 1) ^ 16'hB400 : l >> 1;
  endfunction
  always @(posedge clk or posedge reset)
    if (reset) m_lfsr <= 16'hACE1;
    else m_lfsr <= nx(m_lfsr);
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic move(input logic [3:0] s, input logic col, input logic sub);
    sel_onehot = s; n_row = col; add_n = sub; fire = 1;
    tick();
    fire = 0;
  endtask
  function automatic logic [31:0] scramble_model(input logic [31:0] g0, input logic [15:0] l0);
    logic [31:0] g = g0;
    logic [15:0] l = l0;
    int r, c, p;
    for (int m = 0; m < 16; m++) begin
      for (int k = 0; k < 4; k++) begin
        r = l[15] ? k : int'(l[1:0]);
        c = l[15] ? int'(l[1:0]) : k;
        p = (r*4 + c) * 2;
        g[p +: 2] = g[p +: 2] + 2'd1;
      end
      l = nx(l);
    end
    return g;
  endfunction
  task automatic run_scramble(input string tag);
    logic [15:0] l;
    logic [31:0] exp;
    int cnt = 0;
    int sum = 0;
    exp = state_vec;
    scramble_start = 1;
    tick();
    scramble_start = 0;
    l = m_lfsr;
    exp = scramble_model(exp, l);
    check({tag, "_win_busy"}, {31'd0, win}, 32'd0);
    while (busy && cnt < 100) begin
      sel_onehot = 4'b0010; n_row = 0; add_n = 0; fire = 1;
      tick();
      fire = 0;
      cnt++;
    end
    check({tag, "_busy_cycles"}, cnt, 16);
    check({tag, "_grid"}, state_vec, exp);
    for (int i = 0; i < 16; i++) sum += int'(state_vec[i*2 +: 2]);
    check({tag, "_sum_mod4"}, sum % 4, 0);
    check({tag, "_move_count"}, {16'd0, move_count}, 32'd0);
  endtask
  initial begin
    repeat (2) tick();
    reset = 0;
    tick();
    check("reset_grid", state_vec, 32'h0);
    check("reset_count", {16'd0, move_count}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_win", {31'd0, win}, 32'd1);
    move(4'b0001, 0, 0);
    check("row0_add_grid", state_vec, 32'h00000055);
    check("row0_add_count", {16'd0, move_count}, 32'd1);
    tick();
    check("row0_add_win", {31'd0, win}, 32'd0);
    move(4'b0100, 1, 1);
    check("col2_sub_grid", state_vec, 32'h30303045);
    check("col2_sub_count", {16'd0, move_count}, 32'd2);
    reset = 1;
    #1;
    check("reset_async_grid", state_vec, 32'h0);
    tick();
    reset = 0;
    repeat (4) move(4'b0001, 0, 0);
    check("wrap_grid", state_vec, 32'h0);
    check("wrap_count", {16'd0, move_count}, 32'd4);
    tick();
    check("wrap_win", {31'd0, win}, 32'd1);
    sel_onehot = 4'b0011;
    #1;
    check("sel_error_two", {31'd0, sel_error}, 32'd1);
    sel_onehot = 4'b0000;
    #1;
    check("sel_error_zero", {31'd0, sel_error}, 32'd1);
    move(4'b0011, 0, 0);
    check("sel_error_grid", state_vec, 32'h0);
    check("sel_error_count", {16'd0, move_count}, 32'd4);
    sel_onehot = 4'b1000;
    #1;
    check("sel_ok", {31'd0, sel_error}, 32'd0);
    run_scramble("scr1");
    scramble_start = 1;
    tick();
    scramble_start = 0;
    repeat (4) tick();
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_grid", state_vec, 32'h0);
    check("abort_count", {16'd0, move_count}, 32'd0);
    tick();
    reset = 0;
    tick();
    run_scramble("scr2");
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
